two_of_five_rx: RTL and testbench

TWO_OF_FIVE_RX -- requirements
Module: two_of_five_rx

---
 rtl/two_of_five_rx.sv | 145 ++++++++++++++
 tb/tb_two_of_five_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/two_of_five_rx.sv
// rtl/two_of_five_rx.sv - serial 2-of-5 codeword receiver with error pulses and saturating error count
module two_of_five_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_en,
   input  logic       sin,
   input  logic       clr_err,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       v,
   output logic       new_word,
   output logic       code_err,
   output logic       frame_err,
   output logic [3:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  shift_q, shift_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic [4:0]  word_q,  word_d;
   logic        v_q,     v_d;
   logic        nw_q,    nw_d;
   logic        ce_q,    ce_d;
   logic        fe_q,    fe_d;
   logic [3:0]  err_q,   err_d;
   logic        err_ev;
   logic [2:0]  weight;

   // Number of ones among the five collected data bits.
   always_comb begin
      weight = 3'd0;
      for (int i = 0; i < 5; i++) begin
         weight = weight + {2'b00, shift_q[i]};
      end
   end

   // Frame sequencing: start bit, five data bits (first lands in shift_q[4] = a), then stop bit.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      v_d     = v_q;
      nw_d    = 1'b0;
      ce_d    = 1'b0;
      fe_d    = 1'b0;
      err_ev  = 1'b0;
      if (bit_en) begin
         case (state_q)
            IDLE: begin
               if (!sin) begin
                  state_d = DATA;
                  cnt_d   = 3'd0;
               end
            end
            DATA: begin
               shift_d = {shift_q[3:0], sin};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd4) begin
                  state_d = STOP;
               end
            end
            STOP: begin
               // A zero stop bit returns to IDLE; it is never reused as a start bit.
               state_d = IDLE;
               cnt_d   = 3'd0;
               if (sin && (weight == 3'd2)) begin
                  word_d = shift_q;
                  v_d    = 1'b1;
                  nw_d   = 1'b1;
               end else begin
                  word_d = 5'b00000;
                  v_d    = 1'b0;
                  err_ev = 1'b1;
                  if (sin) begin
                     ce_d = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // Error counter: clear has priority over an error on the same edge; saturates at 15.
   always_comb begin
      err_d = err_q;
      if (clr_err) begin
         err_d = 4'd0;
      end else if (err_ev && (err_q != 4'd15)) begin
         err_d = err_q + 4'd1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= 5'b00000;
         cnt_q   <= 3'd0;
         word_q  <= 5'b00000;
         v_q     <= 1'b0;
         nw_q    <= 1'b0;
         ce_q    <= 1'b0;
         fe_q    <= 1'b0;
         err_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         v_q     <= v_d;
         nw_q    <= nw_d;
         ce_q    <= ce_d;
         fe_q    <= fe_d;
         err_q   <= err_d;
      end
   end

   assign a         = word_q[4];
   assign b         = word_q[3];
   assign c         = word_q[2];
   assign d         = word_q[1];
   assign e         = word_q[0];
   assign v         = v_q;
   assign new_word  = nw_q;
   assign code_err  = ce_q;
   assign frame_err = fe_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_two_of_five_rx.sv
// tb/tb_two_of_five_rx.sv - self-checking bench for two_of_five_rx
module tb_two_of_five_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_en = 1'b0;
   logic       sin = 1'b1;
   logic       clr_err = 1'b0;
   logic       a, b, c, d, e, v, new_word, code_err, frame_err;
   logic [3:0] err_cnt;
   logic [4:0] word;

   int nvec = 0;
   int nmis = 0;

   assign word = {a, b, c, d, e};

   always #5 clk = ~clk;

   two_of_five_rx dut (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sin(sin), .clr_err(clr_err),
      .a(a), .b(b), .c(c), .d(d), .e(e), .v(v),
      .new_word(new_word), .code_err(code_err), .frame_err(frame_err),
      .err_cnt(err_cnt)
   );

   // Reference model: a list of collected bits; -1 means waiting for a start bit.
   int         m_n;
   logic       m_bits [5];
   logic [4:0] m_word;
   logic       m_v, m_nw, m_ce, m_fe;
   int         m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = -1; m_word = 5'b0; m_v = 0; m_nw = 0; m_ce = 0; m_fe = 0; m_cnt = 0;
         for (int i = 0; i < 5; i++) m_bits[i] = 1'b0;
      end else begin
         int  ones;
         bit  err;
         m_nw = 0; m_ce = 0; m_fe = 0; err = 0;
         if (bit_en) begin
            if (m_n < 0) begin
               if (sin == 1'b0) m_n = 0;
            end else if (m_n < 5) begin
               m_bits[m_n] = sin;
               m_n = m_n + 1;
            end else begin
               ones = 0;
               for (int i = 0; i < 5; i++) ones += int'(m_bits[i]);
               if (sin && ones == 2) begin
                  m_word = {m_bits[0], m_bits[1], m_bits[2], m_bits[3], m_bits[4]};
                  m_v = 1; m_nw = 1;
               end else begin
                  m_word = 5'b0; m_v = 0; err = 1;
                  if (sin) m_ce = 1; else m_fe = 1;
               end
               m_n = -1;
            end
         end
         if (clr_err) m_cnt = 0;
         else if (err && m_cnt < 15) m_cnt = m_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("word", {27'b0, word}, {27'b0, m_word});
      chk("v", {31'b0, v}, {31'b0, m_v});
      chk("new_word", {31'b0, new_word}, {31'b0, m_nw});
      chk("code_err", {31'b0, code_err}, {31'b0, m_ce});
      chk("frame_err", {31'b0, frame_err}, {31'b0, m_fe});
      chk("err_cnt", {28'b0, err_cnt}, m_cnt[31:0]);
   end

   task automatic send_bit(input logic bv, input int gap);
      sin = bv; bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0; sin = 1'b1;
      repeat (gap - 1) begin @(posedge clk); #1; end
   endtask

   // Sends start, data (abcde, a first) and stop; returns just after the stop edge.
   task automatic send_frame(input logic [4:0] data, input logic stop, input int gap);
      send_bit(1'b0, gap);
      for (int i = 4; i >= 0; i--) send_bit(data[i], gap);
      sin = stop; bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0; sin = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic bit is_cw(input logic [4:0] p);
      logic [4:0] cws [10];
      cws = '{5'b00110, 5'b10001, 5'b01001, 5'b11000, 5'b00101,
              5'b10100, 5'b01100, 5'b00011, 5'b10010, 5'b01010};
      for (int i = 0; i < 10; i++) if (cws[i] == p) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      #1;
      chk("rst_word", {27'b0, word}, 32'd0);
      chk("rst_v", {31'b0, v}, 32'd0);
      chk("rst_cnt", {28'b0, err_cnt}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // Digit 3 with bit_en every 4th clock.
      send_frame(5'b11000, 1'b1, 4);
      chk("d3_word", {27'b0, word}, 32'b11000);
      chk("d3_v", {31'b0, v}, 32'd1);
      chk("d3_nw", {31'b0, new_word}, 32'd1);
      idle(1);
      chk("d3_nw_drop", {31'b0, new_word}, 32'd0);
      chk("d3_hold", {27'b0, word}, 32'b11000);
      idle(3);

      // Digit 7, then a weight-3 frame.
      send_frame(5'b00011, 1'b1, 1);
      chk("d7_word", {27'b0, word}, 32'b00011);
      idle(2);
      send_frame(5'b11100, 1'b1, 2);
      chk("w3_word", {27'b0, word}, 32'd0);
      chk("w3_v", {31'b0, v}, 32'd0);
      chk("w3_ce", {31'b0, code_err}, 32'd1);
      chk("w3_nw", {31'b0, new_word}, 32'd0);
      chk("w3_cnt", {28'b0, err_cnt}, 32'd1);
      idle(2);

      // Framing error, stop not reused as start, then digit 9.
      send_frame(5'b00110, 1'b0, 1);
      chk("fe_pulse", {31'b0, frame_err}, 32'd1);
      chk("fe_ce", {31'b0, code_err}, 32'd0);
      chk("fe_cnt", {28'b0, err_cnt}, 32'd2);
      send_bit(1'b1, 1);
      send_frame(5'b01010, 1'b1, 1);
      chk("d9_word", {27'b0, word}, 32'b01010);
      chk("d9_v", {31'b0, v}, 32'd1);
      idle(2);

      // Reset after three data bits.
      send_bit(1'b0, 1);
      send_bit(1'b0, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_word", {27'b0, word}, 32'd0);
      chk("mid_rst_v", {31'b0, v}, 32'd0);
      chk("mid_rst_cnt", {28'b0, err_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      send_frame(5'b00101, 1'b1, 3);
      chk("d4_word", {27'b0, word}, 32'b00101);
      chk("d4_v", {31'b0, v}, 32'd1);
      idle(2);

      // Saturation and clear-wins.
      for (int i = 0; i < 16; i++) send_frame(5'b00000, 1'b1, 1);
      chk("sat15", {28'b0, err_cnt}, 32'd15);
      send_frame(5'b11111, 1'b1, 1);
      chk("sat_hold", {28'b0, err_cnt}, 32'd15);
      send_frame(5'b01110, 1'b1, 1);
      chk("sat_hold2", {28'b0, err_cnt}, 32'd15);
      send_bit(1'b0, 1);
      for (int i = 4; i >= 0; i--) send_bit(1'b0, 1);
      sin = 1'b1; bit_en = 1'b1; clr_err = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0; clr_err = 1'b0;
      chk("clr_cnt", {28'b0, err_cnt}, 32'd0);
      chk("clr_ce", {31'b0, code_err}, 32'd1);
      idle(2);

      // Full sweep of data patterns.
      for (int p = 0; p < 32; p++) begin
         logic [4:0] pv;
         pv = p[4:0];
         send_frame(pv, 1'b1, 1);
         chk("sweep_v", {31'b0, v}, {31'b0, is_cw(pv)});
         chk("sweep_ce", {31'b0, code_err}, {31'b0, ~is_cw(pv)});
         if (is_cw(pv)) chk("sweep_word", {27'b0, word}, {27'b0, pv});
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
